axis_tx_frame_fifo: RTL and testbench

- Buffering stage directly downstream of the AES/bypass stream selector, feeding the UART transmit path.
- Absorbs byte bursts from either the cipher channel or the bypass channel, applying AXI-Stream backpressure when full.
- Presents bytes to the transmitter in order, with `tlast` preserved.
- Can optionally hold each frame until it has been completely received (store-and-forward), so the UART never stalls mid-frame.

---
 rtl/axis_tx_frame_fifo_if.sv | 12 +
 rtl/axis_tx_frame_fifo.sv | 88 ++++++++
 tb/tb_axis_tx_frame_fifo.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/axis_tx_frame_fifo_if.sv
// AXI-Stream byte channel used on both sides of the UART TX frame FIFO.
interface taxi_axis_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport src (output tdata, output tvalid, output tlast, input tready);
  modport snk (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_tx_frame_fifo.sv
// Byte FIFO between the AES/bypass selector and UART TX, tlast preserved.
// Define TX_FIFO_PKT_MODE_EN for store-and-forward; default build is cut-through.
module axis_tx_frame_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  taxi_axis_if.snk                 s_axis,
  taxi_axis_if.src                 m_axis,
  output logic [$clog2(DEPTH):0]   status_level,
  output logic [$clog2(DEPTH):0]   status_frames
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [DATA_W:0] mem [DEPTH];
  logic [DATA_W:0] rd_word;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t frame_cnt_q, frame_cnt_d;
  ptr_t status_level_q, status_level_d;
  ptr_t level;

  logic full, empty, release_ok, wr_en, rd_en, in_last, out_last;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign full    = (level == ptr_t'(DEPTH));
  assign rd_word = mem[rd_ptr_q[AW-1:0]];

`ifdef TX_FIFO_PKT_MODE_EN
  // The full term lets frames longer than the buffer stream through instead of deadlocking.
  assign release_ok = (frame_cnt_q != '0) || full;
`else
  assign release_ok = 1'b1;
`endif

  assign s_axis.tready = !full;
  assign m_axis.tvalid = !empty && release_ok;
  assign m_axis.tdata  = rd_word[DATA_W-1:0];
  assign m_axis.tlast  = rd_word[DATA_W];

  assign wr_en    = s_axis.tvalid && !full;
  assign rd_en    = m_axis.tvalid && m_axis.tready;
  assign in_last  = wr_en && s_axis.tlast;
  assign out_last = rd_en && rd_word[DATA_W];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_cnt_d = frame_cnt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + ptr_t'(1);
    case ({in_last, out_last})
      2'b10:   frame_cnt_d = frame_cnt_q + ptr_t'(1);
      2'b01:   frame_cnt_d = frame_cnt_q - ptr_t'(1);
      default: frame_cnt_d = frame_cnt_q;
    endcase
    status_level_d = wr_ptr_d - rd_ptr_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      frame_cnt_q    <= '0;
      status_level_q <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      frame_cnt_q    <= frame_cnt_d;
      status_level_q <= status_level_d;
    end
  end

  // NOTE: storage has no reset; pointers define which entries are valid, so stale data is never seen.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
  end

  assign status_level  = status_level_q;
  assign status_frames = frame_cnt_q;

endmodule

// File: tb/tb_axis_tx_frame_fifo.sv
// Scoreboard bench for axis_tx_frame_fifo: a queue model of buffered beats checks every cycle.
module tb_axis_tx_frame_fifo;

  localparam int DEPTH = 16;
`ifdef TX_FIFO_PKT_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] status_level;
  logic [4:0] status_frames;

  taxi_axis_if #(.DATA_W(8)) s_if ();
  taxi_axis_if #(.DATA_W(8)) m_if ();

  axis_tx_frame_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .status_level  (status_level),
    .status_frames (status_frames)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q [$];   // {tlast, tdata} of beats the FIFO should currently hold, oldest first
  int rdy_mode = 1;        // 0 always ready, 1 never, 2 toggle, 3 random, 4 held by main

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  function automatic int model_frames();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][8]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_if.tready = 1'b1;
      1: m_if.tready = 1'b0;
      2: m_if.tready = ~m_if.tready;
      3: m_if.tready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Monitor: compares observable state to the model, and pops on every output handshake.
  int         mon_sz, mon_fr;
  logic       mon_v;
  logic [8:0] mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      mon_sz = exp_q.size();
      mon_fr = model_frames();
      mon_v  = (mon_sz > 0) && (!PKT || mon_fr > 0 || mon_sz == DEPTH);
      check("status_level", int'(status_level), mon_sz);
      check("status_frames", int'(status_frames), mon_fr);
      check("s_tready", int'(s_if.tready), int'(mon_sz < DEPTH));
      check("m_tvalid", int'(m_if.tvalid), int'(mon_v));
      if (m_if.tvalid && m_if.tready) begin
        if (mon_sz == 0) begin
          check("unexpected_beat", int'(m_if.tvalid), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("m_tdata", int'(m_if.tdata), int'(mon_e[7:0]));
          check("m_tlast", int'(m_if.tlast), int'(mon_e[8]));
        end
      end
    end
  end

  // Driver: presents one beat and records it in the model on the edge that accepts it.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int   waited = 0;
    logic acc = 1'b0;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    while (!acc && waited < 400) begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      if (acc) exp_q.push_back({l, d});
      #1;
      waited++;
    end
    s_if.tvalid = 1'b0;
    if (!acc) check("send_timeout", int'(acc), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int waited = 0;
    rdy_mode = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      idle(1);
      waited++;
    end
    check(name, exp_q.size(), 0);
    idle(2);
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    #2;
    check("reset_tvalid", int'(m_if.tvalid), 0);
    check("reset_tready", int'(s_if.tready), 1);
    check("reset_level", int'(status_level), 0);
    idle(3);
    rst = 1'b0;

    // Short frame, sink always ready.
    rdy_mode = 0;
    idle(1);
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b1);
    drain("short_drain");

    // Fill with the sink stalled, then free one slot while a write waits.
    rdy_mode = 1;
    idle(2);
    for (int i = 0; i < DEPTH; i++) send_beat(8'hA0 + 8'(i), i == DEPTH - 1);
    check("fill_tready", int'(s_if.tready), 0);
    check("fill_level", int'(status_level), DEPTH);
    rdy_mode = 4;
    fork
      send_beat(8'hB0, 1'b1);
      begin
        m_if.tready = 1'b1;
        idle(1);
        m_if.tready = 1'b0;
      end
    join
    check("refill_level", int'(status_level), DEPTH);
    drain("fill_drain");

    // Wrap-around with a toggling sink.
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) send_beat(8'(i), i == 39);
    drain("wrap_drain");

    // 5-byte frame, then a frame longer than the buffer.
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) send_beat(8'h50 + 8'(i), i == 4);
    drain("frame5_drain");
    for (int i = 0; i < 20; i++) send_beat(8'hC0 + 8'(i), i == 19);
    drain("frame20_drain");

    // Reset with 7 bytes buffered: contents must vanish.
    rdy_mode = 1;
    idle(1);
    for (int i = 0; i < 7; i++) send_beat(8'h70 + 8'(i), 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_tvalid", int'(m_if.tvalid), 0);
    check("midrst_tready", int'(s_if.tready), 1);
    check("midrst_level", int'(status_level), 0);
    check("midrst_frames", int'(status_frames), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    idle(6);

    // Randomised traffic with random gaps and sink stalls.
    rdy_mode = 3;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      send_beat(8'($urandom), (i == 299) || ($urandom_range(0, 3) == 0));
    end
    drain("random_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
